// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keycode receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_e;

  // Watchdog counter width; never narrower than one bit for tiny timeouts.
  function automatic int to_cnt_w(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin sync, falling-edge strobe, 11-bit frame FSM, watchdog.
// Odd-parity checking is compiled in with PS2_PARITY_CHECK_EN.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] byte_data,
  output logic       byte_strobe,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int             CW      = to_cnt_w(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    clk_sync, dat_sync;
  logic          clk_prev, fall, dat_smp;
  frame_state_e  state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [CW-1:0] wd_cnt;
  logic          ferr_q, timeout, par_ok;

  // Sync stages idle high so reset never fabricates a falling edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
      fall     <= 1'b0;
      dat_smp  <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      clk_prev <= clk_sync[1];
      fall     <= clk_prev & ~clk_sync[1];
      dat_smp  <= dat_sync[1];
    end
  end

  // An edge on the expiry cycle wins: timeout is masked by fall.
  assign timeout     = (state != IDLE) && !fall && (wd_cnt == TO_LAST);
  assign byte_strobe = fall && (state == STOP) && dat_smp && par_ok;
  assign byte_data   = shreg;
  assign frame_err   = ferr_q | timeout;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
      wd_cnt  <= '0;
      ferr_q  <= 1'b0;
    end else begin
      ferr_q <= fall && (state == STOP) && !dat_smp;
      if (state == IDLE || fall || timeout) wd_cnt <= '0;
      else                                  wd_cnt <= wd_cnt + CW'(1);
      if (timeout) state <= IDLE;
      else if (fall) begin
        case (state)
          IDLE: if (!dat_smp) begin
            bit_cnt <= 3'd0;
            state   <= DATA;
          end
          DATA: begin
            shreg   <= {dat_smp, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY:  state <= STOP;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit, perr_q;

  assign par_ok     = ^{shreg, par_bit};
  assign parity_err = perr_q;

  // A bad stop bit is reported as a frame error only, never both.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      par_bit <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      if (fall && state == PARITY) par_bit <= dat_smp;
      perr_q <= fall && (state == STOP) && dat_smp && !par_ok;
    end
  end
`else
  assign par_ok     = 1'b1;
  assign parity_err = 1'b0;
`endif

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard decoder: strips E0/F0 prefixes and typematic repeats into
// single make events plus a held level. Parity check via PS2_PARITY_CHECK_EN.
module ps2_keycode_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_valid,
  output logic       key_held,
  output logic       frame_err,
  output logic       parity_err
);

  logic [7:0] byte_data;
  logic       byte_strobe;
  logic       ext_f, brk_f, same_key;

  ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_frame (
    .clock       (clock),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_dat     (ps2_dat),
    .byte_data   (byte_data),
    .byte_strobe (byte_strobe),
    .frame_err   (frame_err),
    .parity_err  (parity_err)
  );

  assign same_key = (byte_data == key_code) && (ext_f == key_ext);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      ext_f     <= 1'b0;
      brk_f     <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (byte_strobe) begin
        if (byte_data == PS2_PREFIX_EXT) ext_f <= 1'b1;
        else if (byte_data == PS2_PREFIX_BREAK) brk_f <= 1'b1;
        else begin
          if (brk_f) begin
            if (same_key) key_held <= 1'b0;
          end else if (!(key_held && same_key)) begin
            key_code  <= byte_data;
            key_ext   <= ext_f;
            key_valid <= 1'b1;
            key_held  <= 1'b1;
          end
          ext_f <= 1'b0;
          brk_f <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Randomized bench for ps2_keycode_rx against a byte-level keyboard model.
module tb_ps2_keycode_rx;

  localparam int TO = 200;
  localparam int HB = 15;

  logic       clock = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_dat = 1'b1;
  logic [7:0] key_code;
  logic       key_ext, key_valid, key_held, frame_err, parity_err;

  ps2_keycode_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .key_code(key_code), .key_ext(key_ext), .key_valid(key_valid),
    .key_held(key_held), .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_bad = 0;
  int valid_cnt = 0, ferr_cnt = 0, perr_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) if (!reset) begin
    if (key_valid)  valid_cnt++;
    if (frame_err)  ferr_cnt++;
    if (parity_err) perr_cnt++;
  end

  // Reference: keyboard state after each accepted byte.
  logic [7:0] m_code = 8'h00;
  logic       m_ext = 1'b0, m_held = 1'b0, m_ef = 1'b0, m_bf = 1'b0;
  int         m_valid = 0, m_perr = 0, m_ferr = 0;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  function automatic void model_byte(input logic [7:0] b);
    bit same;
    if (b == 8'hE0) m_ef = 1'b1;
    else if (b == 8'hF0) m_bf = 1'b1;
    else begin
      same = (b == m_code) && (m_ef == m_ext);
      if (m_bf) begin
        if (same) m_held = 1'b0;
      end else if (!(m_held && same)) begin
        m_code = b; m_ext = m_ef; m_held = 1'b1; m_valid++;
      end
      m_ef = 1'b0; m_bf = 1'b0;
    end
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic ps2_bit(input logic v);
    ps2_dat = v;
    wait_cyc(HB);
    ps2_clk = 1'b0;
    wait_cyc(HB);
    ps2_clk = 1'b1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".code"},  key_code, m_code);
    chk({tag, ".ext"},   key_ext,  m_ext);
    chk({tag, ".held"},  key_held, m_held);
    chk({tag, ".nvld"},  valid_cnt, m_valid);
    chk({tag, ".nperr"}, perr_cnt, m_perr);
    chk({tag, ".nferr"}, ferr_cnt, m_ferr);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(~bad_stop);
    ps2_dat = 1'b1;
    wait_cyc(HB + 10);
    if (bad_stop) m_ferr++;
    else if (bad_par && PCHK) m_perr++;
    else model_byte(b);
  endtask

  task automatic send_seq(input string tag, input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_frame(bytes[i], 1'b0, 1'b0);
    check_state(tag);
  endtask

  localparam logic [7:0] KEYS [13] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                       8'h3D, 8'h3E, 8'h46, 8'h75, 8'h72, 8'h6B, 8'h74};

  initial begin
    logic [7:0] q[$];
    int k, kind;
    logic [7:0] code;
    bit ext;

    wait_cyc(4);
    chk("rst.code", key_code, 8'h00);
    chk("rst.ext", key_ext, 1'b0);
    chk("rst.held", key_held, 1'b0);
    chk("rst.pulses", {key_valid, frame_err, parity_err}, 3'b000);
    reset = 1'b0;
    wait_cyc(5);

    send_seq("make1E", '{8'h1E});
    send_seq("extmake75", '{8'hE0, 8'h75});
    send_seq("extbrk75", '{8'hE0, 8'hF0, 8'h75});
    send_seq("typematic16", '{8'h16, 8'h16, 8'h16});
    send_seq("brk16", '{8'hF0, 8'h16});
    send_seq("make1E_again", '{8'h1E});
    send_seq("make46_held", '{8'h46});
    send_seq("brk_stale1E", '{8'hF0, 8'h1E});
    send_seq("brk_ext46", '{8'hE0, 8'hF0, 8'h46});

    send_frame(8'h26, 1'b1, 1'b0);
    check_state("badpar26");
    send_frame(8'h3D, 1'b0, 1'b1);
    check_state("badstop3D");

    // Abandon a frame after 4 data bits and let the watchdog fire.
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    wait_cyc(TO + 20);
    m_ferr++;
    check_state("timeout");
    send_seq("after_to25", '{8'h25});

    // Reset in the middle of a frame while a key is held.
    chk("pre_rst.held", key_held, 1'b1);
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b0);
    #3 reset = 1'b1;
    #1;
    chk("midrst.code", key_code, 8'h00);
    chk("midrst.held", key_held, 1'b0);
    chk("midrst.pulses", {key_ext, key_valid, frame_err, parity_err}, 4'b0000);
    m_code = 8'h00; m_ext = 1'b0; m_held = 1'b0; m_ef = 1'b0; m_bf = 1'b0;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(5);
    send_seq("post_rst2E", '{8'h2E});

    for (int it = 0; it < 45; it++) begin
      k = $urandom_range(0, 12);
      kind = $urandom_range(0, 9);
      code = KEYS[k];
      ext = (k >= 9);
      if (kind == 8 && m_code != 8'h00) begin code = m_code; ext = m_ext; end
      q = {};
      if (ext) q.push_back(8'hE0);
      if (kind == 6 || kind == 7) q.push_back(8'hF0);
      q.push_back(code);
      foreach (q[i]) send_frame(q[i], $urandom_range(0, 11) == 0, $urandom_range(0, 19) == 0);
      check_state($sformatf("rnd%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
